// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between the serial adder and its requester.
// The ovf member exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first (SERIAL_ADDER_OVF_EN adds ovf).
// Latency: WIDTH clocks from the accepted start edge to the done pulse; one result per WIDTH+1 clocks.
// Backpressure: start is taken only while ready (IDLE/DONE); start during RUN is dropped, not queued.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             sbit;
    logic             cnext;

    always_comb begin
        sbit    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        cnext   = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    c_d     = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {sbit, res_q[WIDTH-1:1]};
                c_d    = cnext;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q here is the carry into the MSB, cnext the carry out of it
                    sum_d   = {sbit, res_q[WIDTH-1:1]};
                    cout_d  = cnext;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = c_q ^ cnext;
`endif
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.ready = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors plus exhaustive WIDTH=2 sweep.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w8_unexpected_done: got sum=%0h expected no done", bus8.sum);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_sum", 32'(bus8.sum), 32'(e.sum));
                check("w8_cout", 32'(bus8.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("w8_ovf", 32'(bus8.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.done === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w2_unexpected_done: got sum=%0h expected no done", bus2.sum);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("w2_sum", 32'(bus2.sum), 32'(e.sum[1:0]));
                check("w2_cout", 32'(bus2.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("w2_ovf", 32'(bus2.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Returns just after the accepted start edge (t0 + 1 time unit)
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        bus8.a = a;
        bus8.b = b;
        bus8.cin = c;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    task automatic wait_done8(output int cycles);
        cycles = 0;
        while (bus8.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("w8_done_seen", 32'(bus8.done), 32'd1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        q8.push_back('{sum: es, cout: ec, ovf: eo});
        issue8(a, b, c);
        wait_done8(cyc);
        check("w8_latency", 32'(cyc), 32'd8);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] full;
        logic       ov;
        int         cyc;
        full = {1'b0, a} + {1'b0, b} + {2'b00, c};
        ov   = (a[1] == b[1]) && (full[1] != a[1]);
        q2.push_back('{sum: {6'b0, full[1:0]}, cout: full[2], ovf: ov});
        @(negedge clk);
        bus2.a = a;
        bus2.b = b;
        bus2.cin = c;
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("w2_latency", 32'(cyc), 32'd2);
    endtask

    initial begin
        int   busy_cnt;
        int   done_at;
        int   d1;
        int   d2;
        int   cyc;
        bit   hold_ok;
        bit   seen;
        logic [7:0] prev;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

        #12;
        check("rst_ready", 32'(bus8.ready), 32'd1);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero operands: done 8 edges after start, busy for 8 cycles
        q8.push_back('{sum: 8'h00, cout: 1'b0, ovf: 1'b0});
        issue8(8'h00, 8'h00, 1'b0);
        busy_cnt = int'(bus8.busy);
        done_at  = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus8.busy === 1'b1) busy_cnt++;
            if (bus8.done === 1'b1 && done_at == 0) done_at = k;
        end
        check("t1_done_at", 32'(done_at), 32'd8);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd8);

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Start pulse mid-RUN must be ignored; sum holds until completion
        prev = bus8.sum;
        q8.push_back('{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        issue8(8'h5A, 8'hA5, 1'b1);
        hold_ok = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus8.sum !== prev) hold_ok = 1'b0;
        end
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        bus8.cin = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        cyc = 3;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (bus8.sum !== prev) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t4_latency", 32'(cyc), 32'd8);
        check("t4_sum_held", 32'(hold_ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_idle_after", 32'(bus8.busy), 32'd0);

        // Back-to-back with start held through DONE
        q8.push_back('{sum: 8'h30, cout: 1'b0, ovf: 1'b0});
        q8.push_back('{sum: 8'h03, cout: 1'b0, ovf: 1'b0});
        @(negedge clk);
        bus8.a = 8'h10;
        bus8.b = 8'h20;
        bus8.cin = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.a = 8'h01;
        bus8.b = 8'h02;
        d1 = 0;
        d2 = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40 && d2 == 0; k++) begin
            @(posedge clk);
            #1;
            if (d1 != 0 && k == d1 + 1) bus8.start = 1'b0;
            if (bus8.done === 1'b1) begin
                if (d1 == 0) d1 = k;
                else d2 = k;
            end else if (d1 != 0 && bus8.sum !== 8'h30) begin
                hold_ok = 1'b0;
            end
        end
        bus8.start = 1'b0;
        check("b2b_first_done", 32'(d1), 32'd8);
        check("b2b_spacing", 32'(d2 - d1), 32'd9);
        check("b2b_sum_held", 32'(hold_ok), 32'd1);

        // Reset 4 edges into RUN discards the operation
        issue8(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus8.ready), 32'd1);
        check("mid_rst_busy", 32'(bus8.busy), 32'd0);
        check("mid_rst_done", 32'(bus8.done), 32'd0);
        check("mid_rst_sum", 32'(bus8.sum), 32'd0);
        check("mid_rst_cout", 32'(bus8.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) seen = 1'b1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);

        op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

        // WIDTH=2 exhaustive sweep
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            op2(v[4:3], v[2:1], v[0]);
        end

        repeat (4) @(posedge clk);
        #1;
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
